// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad input path: channel map, clock rate, debounce defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package gamepad_pkg;

    localparam int N_CH_DEFAULT        = 6;
    localparam int CH_DPAD0            = 0;
    localparam int CH_DPAD1            = 1;
    localparam int CH_A                = 2;
    localparam int CH_B                = 3;
    localparam int CH_PAUSE            = 4;
    localparam int CH_SPARE            = 5;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_MS_DEFAULT = 10;

    typedef logic [N_CH_DEFAULT-1:0] btn_vec_t;

    function automatic int cycles_from_ms(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/gamepad_input_conditioner_debounce.sv
// One button channel: synchroniser chain, debounce counter, press/release pulses, optional auto-repeat (GAMEPAD_AUTOREPEAT_EN).
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles from a stable pin edge to state/pulse.
// Backpressure: none; pulses are single-cycle and unbuffered.
module input_debounce_ch
    import gamepad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS_DEFAULT),
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic pin_raw,
    output logic state,
    output logic press_pls,
    output logic release_pls
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   raw;
    logic                   commit;
    logic                   rep_fire;

    // Input arrives polarity-normalised, so reset value 0 is the inactive pin level.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw};
        end
    end

    assign raw    = sync_q[SYNC_STAGES-1];
    assign commit = (raw != state) && (cnt == CNT_MAX);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt         <= '0;
            state       <= 1'b0;
            press_pls   <= 1'b0;
            release_pls <= 1'b0;
        end else begin
            press_pls   <= (commit & raw) | rep_fire;
            release_pls <= commit & ~raw;
            if (raw == state) begin
                cnt <= '0;
            end else if (commit) begin
                state <= raw;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef GAMEPAD_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("need REPEAT_DELAY >= 2 and 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    logic [HOLD_W-1:0] hold_cnt;

    // Release edge takes priority so a repeat never lands on the release cycle.
    assign rep_fire = state && !commit && (hold_cnt == HOLD_MAX);

    // Reloading to DELAY-PERIOD makes every later repeat exactly PERIOD cycles apart.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            hold_cnt <= '0;
        end else if (!state || commit) begin
            hold_cnt <= '0;
        end else if (rep_fire) begin
            hold_cnt <= HOLD_RELOAD;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/gamepad_input_conditioner.sv
// N-channel GPIO button conditioner: polarity normalise, synchronise, debounce, press/release pulses; GAMEPAD_AUTOREPEAT_EN adds held-button repeat.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES cycles pin edge to btn_state/pulse; any_press same cycle as btn_press.
// Backpressure: none; outputs are levels and single-cycle pulses.
module gamepad_input_conditioner
    import gamepad_pkg::*;
#(
    parameter int N_CH            = N_CH_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = cycles_from_ms(DEBOUNCE_MS_DEFAULT),
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N_CH-1:0] pin_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            any_press
);

    logic [N_CH-1:0] pin_norm;

    // XOR with a constant is a plain wire/inverter, so it is safe ahead of the synchroniser.
    assign pin_norm = pin_in ^ {N_CH{ACTIVE_LOW}};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .core_clk    (CLK),
            .arst_n      (RESET),
            .pin_raw     (pin_norm[i]),
            .state       (btn_state[i]),
            .press_pls   (btn_press[i]),
            .release_pls (btn_release[i])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_gamepad_input_conditioner.sv
// Randomised and directed bench for gamepad_input_conditioner against a window-based reference model.
// Model: a channel flips when the last DEBOUNCE_CYCLES post-reset synchronised samples all differ from its level.
module tb_gamepad_input_conditioner;

    localparam int N    = 6;
    localparam int SYNC = 2;
    localparam int DC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXC = 8192;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [N-1:0] pin_in;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    gamepad_input_conditioner #(
        .N_CH            (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .pin_in      (pin_in),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Pressed-level (normalised) value seen by the first sync flop at each edge; 0 while in reset.
    logic [N-1:0] samp [MAXC];
    bit           rst_at [MAXC];
    int           cyc = 0;
    logic [N-1:0] m_state, m_press, m_rel;
    int           rise_at [N];

    task automatic model_edge();
        bit flip;
        for (int ch = 0; ch < N; ch++) begin
            m_press[ch] = 1'b0;
            m_rel[ch]   = 1'b0;
            if (rst_at[cyc]) begin
                m_state[ch] = 1'b0;
                rise_at[ch] = -1;
            end else begin
                flip = (cyc >= SYNC + DC);
                for (int j = 0; j < DC; j++) begin
                    if (flip && (rst_at[cyc-j] || samp[cyc-j-SYNC][ch] == m_state[ch]))
                        flip = 1'b0;
                end
                if (flip) begin
                    m_state[ch] = ~m_state[ch];
                    if (m_state[ch]) begin
                        m_press[ch] = 1'b1;
                        rise_at[ch] = cyc;
                    end else begin
                        m_rel[ch] = 1'b1;
                    end
                end
`ifdef GAMEPAD_AUTOREPEAT_EN
                else if (m_state[ch] && (cyc - rise_at[ch]) >= RD && ((cyc - rise_at[ch] - RD) % RP) == 0) begin
                    m_press[ch] = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        rst_at[cyc] = !RESET;
        samp[cyc]   = RESET ? ~pin_in : '0;
        model_edge();
        #1;
        check("btn_state",   32'(btn_state),   32'(m_state));
        check("btn_press",   32'(btn_press),   32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_rel));
        check("any_press",   32'(any_press),   32'(|m_press));
        check("press_release_overlap", 32'(btn_press & btn_release), 32'd0);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous assertion: outputs must clear without waiting for an edge.
    task automatic assert_reset();
        RESET = 1'b0;
        #1;
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        check("async_reset_state", 32'(btn_state),   32'd0);
        check("async_reset_press", 32'(btn_press),   32'd0);
        check("async_reset_rel",   32'(btn_release), 32'd0);
        check("async_reset_any",   32'(any_press),   32'd0);
    endtask

    task automatic measure_rise(input string tag, input int ch);
        int lat;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (btn_state[ch]) begin
                lat = i;
                break;
            end
        end
        check(tag, 32'(lat), 32'(SYNC + DC));
    endtask

    initial begin
        int rate;
        for (int ch = 0; ch < N; ch++) rise_at[ch] = -1;
        m_state = '0;
        m_press = '0;
        m_rel   = '0;
        RESET   = 1'b0;
        pin_in  = '1;

        // Reset then idle
        steps(3);
        RESET = 1'b1;
        steps(20);

        // Clean press on ch2, held long enough for any repeats, then release
        pin_in[2] = 1'b0;
        measure_rise("press_latency_ch2", 2);
        steps(25);
        pin_in[2] = 1'b1;
        steps(15);

        // Glitch rejection and bounce on ch3
        pin_in[3] = 1'b0; steps(3);
        pin_in[3] = 1'b1; steps(10);
        pin_in[3] = 1'b0; step();
        pin_in[3] = 1'b1; step();
        pin_in[3] = 1'b0;
        measure_rise("bounce_latency_ch3", 3);
        steps(5);
        pin_in[3] = 1'b1; steps(10);

        // Simultaneous press, independent release
        pin_in[0] = 1'b0; pin_in[4] = 1'b0; steps(10);
        pin_in[0] = 1'b1; steps(10);
        pin_in[4] = 1'b1; steps(10);

        // Reset in the middle of a debounce on ch1
        pin_in[1] = 1'b0;
        steps(4);
        assert_reset();
        steps(2);
        RESET = 1'b1;
        measure_rise("post_reset_latency_ch1", 1);
        steps(5);
        pin_in[1] = 1'b1;
        steps(10);

        // Random traffic: blocks of calm, bouncy and noisy pins, rare resets
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0:       rate = 1;
                1:       rate = 6;
                default: rate = 30;
            endcase
            for (int c = 0; c < 200; c++) begin
                for (int ch = 0; ch < N; ch++) begin
                    if ($urandom_range(0, 99) < rate) pin_in[ch] = ~pin_in[ch];
                end
                if ($urandom_range(0, 499) == 0) begin
                    assert_reset();
                    steps(2);
                    RESET = 1'b1;
                end
                step();
            end
        end

        pin_in = '1;
        steps(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
